// File: rtl/threedemux_reg.sv
// rtl/threedemux_reg.sv - registered 1-to-3 demultiplexer with valid/ready handshaking
//
// Routes one WIDTH-bit input stream to one of three output channels chosen by
// in_sel. Each channel owns a one-entry holding register so the three
// consumers stall independently. in_sel = 3 is illegal: the word is accepted,
// dropped, flagged on err for one cycle and counted in a saturating counter.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_data, in_sel, in_valid  producer word, destination select, valid
//   in_ready                   combinational accept for the selected destination
//   outN_data, outN_valid      channel N holding register and its full flag
//   outN_ready                 channel N consumer takes the word this cycle
//   err                        one-cycle pulse after an illegal-select word is accepted
//   err_count                  saturating count of illegal-select words

module threedemux_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out3_data,
    output logic             out3_valid,
    input  logic             out3_ready,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       valid_q, valid_d;
    logic [2:0]       ready_vec;
    logic [2:0]       load;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [WIDTH-1:0] data2_q, data2_d;
    logic [WIDTH-1:0] data3_q, data3_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             illegal;

    always_comb begin
        ready_vec = {out3_ready, out2_ready, out1_ready};

        // Only the selected channel gates acceptance; a full channel whose
        // consumer is draining this cycle can still take the new word.
        case (in_sel)
            2'd0:    in_ready = !valid_q[0] || ready_vec[0];
            2'd1:    in_ready = !valid_q[1] || ready_vec[1];
            2'd2:    in_ready = !valid_q[2] || ready_vec[2];
            default: in_ready = 1'b1;
        endcase

        accept  = in_valid && in_ready;
        load    = 3'b000;
        illegal = 1'b0;
        case (in_sel)
            2'd0:    load[0] = accept;
            2'd1:    load[1] = accept;
            2'd2:    load[2] = accept;
            default: illegal = accept;
        endcase

        // Load wins over drain, so a simultaneous load and drain keeps valid high.
        valid_d = load | (valid_q & ~ready_vec);

        data1_d = load[0] ? in_data : data1_q;
        data2_d = load[1] ? in_data : data2_q;
        data3_d = load[2] ? in_data : data3_q;

        err_d = illegal;
        cnt_d = cnt_q;
        if (illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 3'b000;
            data1_q <= '0;
            data2_q <= '0;
            data3_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            data3_q <= data3_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out1_data  = data1_q;
    assign out2_data  = data2_q;
    assign out3_data  = data3_q;
    assign out1_valid = valid_q[0];
    assign out2_valid = valid_q[1];
    assign out3_valid = valid_q[2];
    assign err        = err_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_threedemux_reg.sv
// tb/tb_threedemux_reg.sv - scoreboard bench for threedemux_reg

module tb_threedemux_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1_data, out2_data, out3_data;
    logic        out1_valid, out2_valid, out3_valid;
    logic        out1_ready, out2_ready, out3_ready;
    logic        err;
    logic [7:0]  err_count;

    logic        s_in_ready;
    logic [31:0] s1_data, s2_data, s3_data;
    logic        s1_valid, s2_valid, s3_valid;
    logic        s_err;
    logic [1:0]  s_err_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];
    logic [31:0] exp_q3[$];
    logic [7:0]  exp_err_q[$];
    int          exp_cnt = 0;

    threedemux_reg #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
        .out3_data(out3_data), .out3_valid(out3_valid), .out3_ready(out3_ready),
        .err(err), .err_count(err_count)
    );

    threedemux_reg #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(s_in_ready),
        .out1_data(s1_data), .out1_valid(s1_valid), .out1_ready(out1_ready),
        .out2_data(s2_data), .out2_valid(s2_valid), .out2_ready(out2_ready),
        .out3_data(s3_data), .out3_valid(s3_valid), .out3_ready(out3_ready),
        .err(s_err), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected word for every channel transfer and the
    // expected counter value for every err pulse.
    always @(negedge clk) begin
        if (out1_valid === 1'b1 && out1_ready === 1'b1) begin
            if (exp_q1.size() == 0) chk("ch1 unexpected word", out1_data, 32'hxxxx_xxxx);
            else chk("ch1 data", out1_data, exp_q1.pop_front());
        end
        if (out2_valid === 1'b1 && out2_ready === 1'b1) begin
            if (exp_q2.size() == 0) chk("ch2 unexpected word", out2_data, 32'hxxxx_xxxx);
            else chk("ch2 data", out2_data, exp_q2.pop_front());
        end
        if (out3_valid === 1'b1 && out3_ready === 1'b1) begin
            if (exp_q3.size() == 0) chk("ch3 unexpected word", out3_data, 32'hxxxx_xxxx);
            else chk("ch3 data", out3_data, exp_q3.pop_front());
        end
        if (err === 1'b1) begin
            if (exp_err_q.size() == 0) chk("unexpected err pulse", 32'(err), 32'd0);
            else chk("err_count at pulse", 32'(err_count), 32'(exp_err_q.pop_front()));
        end
    end

    // Presents a word, waits (bounded) for acceptance and records the expectation.
    task automatic send(input logic [31:0] d, input logic [1:0] s);
        int n = 0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("send timeout", 32'(in_ready), 32'd1);
        end else begin
            case (s)
                2'd0: exp_q1.push_back(d);
                2'd1: exp_q2.push_back(d);
                2'd2: exp_q3.push_back(d);
                default: begin
                    if (exp_cnt < 255) exp_cnt++;
                    exp_err_q.push_back(8'(exp_cnt));
                end
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0;
        out1_ready = 1'b0; out2_ready = 1'b0; out3_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        #1;
        chk("reset valids", {29'd0, out3_valid, out2_valid, out1_valid}, 32'd0);
        chk("reset data1", out1_data, 32'd0);
        chk("reset data3", out3_data, 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset err_count", 32'(err_count), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Single word to channel 2, consumers stalled: it must be held.
        send(32'hDEADBEEF, 2'd1);
        chk("t1 out2_valid", 32'(out2_valid), 32'd1);
        chk("t1 out2_data", out2_data, 32'hDEADBEEF);
        chk("t1 other valids", {30'd0, out3_valid, out1_valid}, 32'd0);
        tick(3);
        chk("t1 hold valid", 32'(out2_valid), 32'd1);
        chk("t1 hold data", out2_data, 32'hDEADBEEF);
        out2_ready = 1'b1; tick(1); out2_ready = 1'b0;
        chk("t1 drained", 32'(out2_valid), 32'd0);

        // Channel 1 full and stalled: sel 0 blocks, sel 1 still passes.
        send(32'h0000_00A1, 2'd0);
        in_data = 32'h0000_00A2; in_sel = 2'd0; in_valid = 1'b1; #1;
        chk("t4 ch1 backpressure", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        in_sel = 2'd1; #1;
        chk("t4 sel1 ready", 32'(in_ready), 32'd1);
        send(32'h0000_00B2, 2'd1);
        chk("t4 out2_data", out2_data, 32'h0000_00B2);
        chk("t4 ch1 unchanged", out1_data, 32'h0000_00A1);
        chk("t4 ch1 valid", 32'(out1_valid), 32'd1);

        // Channel 3 full: stall, then same-cycle drain and reload.
        send(32'h0000_0033, 2'd2);
        in_data = 32'h0000_0044; in_sel = 2'd2; in_valid = 1'b1; #1;
        chk("t2 ch3 stall", 32'(in_ready), 32'd0);
        out3_ready = 1'b1; #1;
        chk("t2 ready follows out3_ready", 32'(in_ready), 32'd1);
        send(32'h0000_0044, 2'd2);
        out3_ready = 1'b0;
        chk("t2 out3_valid stays", 32'(out3_valid), 32'd1);
        chk("t2 out3 new word", out3_data, 32'h0000_0044);

        // Back-to-back stream into channel 1 with the consumer always ready.
        out1_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_sel = 2'd0; #1;
            chk("t3 in_ready", 32'(in_ready), 32'd1);
            send(32'(k), 2'd0);
            chk("t3 out1_data", out1_data, 32'(k));
        end
        out1_ready = 1'b0;

        // Four illegal words: four pulses, count 4, small counter saturates at 3.
        for (int k = 0; k < 4; k++) send(32'hBAD0_0000 + 32'(k), 2'd3);
        tick(1);
        chk("t5 err_count", 32'(err_count), 32'd4);
        chk("t5 small err_count sat", 32'(s_err_count), 32'd3);
        chk("t5 err low after burst", 32'(err), 32'd0);
        chk("t5 valids unchanged", {29'd0, out3_valid, out2_valid, out1_valid}, 32'd7);
        chk("t5 ch1 data unchanged", out1_data, 32'd4);

        // Reset with channels full and an illegal word presented.
        in_data = 32'h0000_0099; in_sel = 2'd3; in_valid = 1'b1; reset = 1'b1;
        tick(1);
        reset = 1'b0; in_valid = 1'b0;
        exp_q1.delete(); exp_q2.delete(); exp_q3.delete(); exp_cnt = 0;
        chk("t6 valids", {29'd0, out3_valid, out2_valid, out1_valid}, 32'd0);
        chk("t6 data2", out2_data, 32'd0);
        chk("t6 err_count", 32'(err_count), 32'd0);
        chk("t6 err", 32'(err), 32'd0);
        tick(1);
        chk("t6 word not loaded", 32'(err_count), 32'd0);

        // Post-reset flow still works.
        send(32'h1234_5678, 2'd1);
        out2_ready = 1'b1; tick(1); out2_ready = 1'b0;
        tick(1);
        chk("end ch1 queue empty", 32'(exp_q1.size()), 32'd0);
        chk("end ch2 queue empty", 32'(exp_q2.size()), 32'd0);
        chk("end err queue empty", 32'(exp_err_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/threedemux_reg.md
# threedemux_reg

Registered 1-to-3 demultiplexer with valid/ready handshaking: the fan-out counterpart of the CPU's 3-input result mux. It takes one WIDTH-bit stream plus a 2-bit select and delivers each word to exactly one of three output channels. Each channel has its own one-entry holding register. It sits between a single producer (e.g. ALU/memory result bus) and three independent consumers, decoupling their stall behaviour. Select value 3 is illegal: the word is dropped, flagged and counted.

## Interface
- WIDTH, 32, data width of input and all outputs
- CNT_W, 8, width of the saturating illegal-select counter

- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination: 0 → channel 1, 1 → channel 2, 2 → channel 3, 3 → illegal
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block accepts the word this cycle
- out1_data / out2_data / out3_data  output  WIDTH each  registered channel data
- out1_valid / out2_valid / out3_valid  output  1 each  channel holds an undelivered word
- out1_ready / out2_ready / out3_ready  input  1 each  consumer takes the word this cycle
- err  output  1  one-cycle pulse: an illegal-select word was accepted last cycle
- err_count  output  CNT_W  number of illegal-select words accepted; saturates at all-ones

## Operation
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Channel n transfer: outn_valid && outn_ready.
- in_ready is combinational:
  - in_sel = 3: 1.
  - Otherwise, for selected channel n: !outn_valid || outn_ready.
  - in_ready does not depend on in_valid.
  - Unselected channels never affect in_ready.
- Accepted word, in_sel = n ∈ {0,1,2}:
  - Channel n+1 data register loads in_data.
  - Its valid is set next cycle.
  - Other channels are untouched.
- Accepted word, in_sel = 3:
  - No channel changes.
  - err = 1 next cycle.
  - err_count increments by 1, unless already all-ones.
- Channel valid update, per channel, each cycle:
  - Set if loaded.
  - Else cleared if transferred.
  - Else held.
- Simultaneous load and drain on the same channel (full, ready=1, new word selected):
  - New word replaces old.
  - Valid stays 1.
  - No bubble, no loss.
- Data registers change only on load. outn_data holds its value while outn_valid = 1 and outn_ready = 0.
- Order within a channel is preserved. Channels are mutually independent; no ordering across channels.
- in_sel/in_data are sampled only on the accept edge. Changing them while in_ready = 0 is allowed.

## Timing
- Reset (synchronous, dominates all other activity in that cycle):
  - out1/2/3_valid = 0.
  - out1/2/3_data = 0.
  - err = 0.
  - err_count = 0.
  - in_ready then follows its combinational rule (1 after reset, since all channels are empty).
- Reset asserted mid-operation: held words are discarded, no transfers complete, and a word presented that cycle is not loaded.
- Latency: a word accepted at edge k is visible as outn_valid = 1 in cycle k+1.
- Throughput: one word per cycle into any channel whose consumer holds ready = 1, including back-to-back words to the same channel.
- Back-pressure: with channel n full and outn_ready = 0, words selecting n stall (in_ready = 0); the producer must hold them.
- err is high for exactly one cycle per illegal word. Consecutive illegal words give consecutive err pulses.
- err_count wraps never; it saturates at 2^CNT_W − 1.

## Test plan
- Reset, then in_data = 0xDEADBEEF, in_sel = 1, in_valid = 1 for one cycle, all out_ready = 0 → next cycle out2_valid = 1 with out2_data = 0xDEADBEEF; out1_valid = out3_valid = 0; out2 holds indefinitely.
- Channel 3 full, out3_ready = 0, new word with in_sel = 2 → in_ready = 0. Raise out3_ready → in_ready = 1 same cycle; the old word is delivered and the new word appears next cycle with out3_valid still 1.
- Stream 0x1,0x2,0x3,0x4 with in_sel = 0, out1_ready = 1 constantly → in_ready = 1 every cycle; out1_data shows 1,2,3,4 on consecutive cycles.
- Channel 1 full and stalled, then word with in_sel = 1 → in_ready = 1, accepted, out2 loads, channel 1 unchanged.
- Four words with in_sel = 3 → four one-cycle err pulses; err_count = 4; no out_valid asserts. With CNT_W = 2, the count stops at 3.
- Channels 1 and 2 full, assert reset for one cycle while in_valid = 1 → all valids = 0, data = 0, err_count = 0; the input word is not loaded.
